gray_counter: RTL

GRAY_COUNTER -- requirements
Module: gray_counter

---
 rtl/gray_counter.sv | 107 ++++++++++
 1 files changed

// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
// Module      : gray_counter
// Description : Up/down counter that presents its count in both binary and
//               reflected Gray code. A single binary count register is
//               kept; the Gray value is registered alongside it so both
//               outputs change on the same edge and come straight from flops.
//               A one-cycle wrap pulse marks every all-ones -> all-zeros
//               (up) or all-zeros -> all-ones (down) transition.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH    : counter width in bits (2..32)
//   INIT     : binary reset value, truncated to WIDTH bits
// Ports
//   clk      : in  1      clock, all state updates on the rising edge
//   rst_n    : in  1      synchronous active-low reset
//   en       : in  1      count enable
//   up       : in  1      direction, 1 = increment, 0 = decrement
//   load     : in  1      synchronous load strobe (beats en)
//   load_bin : in  WIDTH  binary value taken on load
//   gray     : out WIDTH  registered Gray-code count
//   bin      : out WIDTH  registered binary count
//   wrap     : out 1      registered single-cycle wrap-around pulse
// ============================================================================
module gray_counter #(
    parameter int          WIDTH = 4,
    parameter int unsigned INIT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             wrap
);

    // Binary-to-Gray conversion: each Gray bit is the XOR of neighbouring
    // binary bits, so any +/-1 step flips exactly one Gray bit.
    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    localparam logic [WIDTH-1:0] c_init_bin  = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] c_init_gray = to_gray(c_init_bin);
    localparam logic [WIDTH-1:0] c_one       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_all_ones  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_all_zeros = {WIDTH{1'b0}};

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_q;
    logic             wrap_d;

    logic [WIDTH-1:0] w_bin_inc;
    logic [WIDTH-1:0] w_bin_dec;

    // Modular arithmetic falls out of the fixed-width adders.
    assign w_bin_inc = bin_q + c_one;
    assign w_bin_dec = bin_q - c_one;

    // Next-state selection: load beats count, count beats hold. The wrap
    // flag is cleared by every non-wrapping action, including a load of
    // the current value, so it can never linger past one cycle.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (up) begin
                bin_d  = w_bin_inc;
                wrap_d = (bin_q == c_all_ones);
            end else begin
                bin_d  = w_bin_dec;
                wrap_d = (bin_q == c_all_zeros);
            end
        end
        // Gray is derived from the next binary value and then registered,
        // keeping the output free of any combinational path.
        gray_d = to_gray(bin_d);
    end

    // Reset overrides load and en; an in-progress step is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= c_init_bin;
            gray_q <= c_init_gray;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;

endmodule
`default_nettype wire
